// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory controller.
// Takes the EX/MEM register outputs and runs each load/store over a req/ack
// bus. It stalls the upstream pipeline until the access finishes and drives
// the MEM/WB register consumed by write-back. It also flags misaligned word
// accesses and bus timeouts.
// Ports:
//   clk, reset (async, active-low)
//   *_mem          : EX/MEM register outputs (control, destination, address/result, store data)
//   dmem_*         : req/ack data-memory bus; req/we/addr/wdata registered
//   stall_mem      : combinational hold for IF/ID/EX/EX-MEM
//   *_wb           : MEM/WB register outputs
//   misalign_err   : one-cycle pulse on a misaligned memory access
//   bus_timeout    : one-cycle pulse when a request is abandoned
module mem_stage_dmem_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite_mem,
    input  logic        MemToReg_mem,
    input  logic        RegWrite_mem,
    input  logic [4:0]  RegWriteAddr_mem,
    input  logic [31:0] ALUResult_mem,
    input  logic [31:0] MemWriteData_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mem,
    output logic        RegWrite_wb,
    output logic [4:0]  RegWriteAddr_wb,
    output logic        MemToReg_wb,
    output logic [31:0] ReadData_wb,
    output logic [31:0] ALUResult_wb,
    output logic        misalign_err,
    output logic        bus_timeout
);

    localparam int unsigned CntW = 8;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t          state, stateNext;
    logic [CntW-1:0] cnt;
    logic            timedOut;
    logic [31:0]     rdataQ;
    logic            memop, aligned;
    logic            startAccess, accessAck, accessAbort, misalign;

    assign memop   = MemWrite_mem | MemToReg_mem;
    assign aligned = (ALUResult_mem[1:0] == 2'b00);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // Next state, stall and per-cycle access decisions
    always_comb begin
        stateNext   = state;
        stall_mem   = 1'b0;
        startAccess = 1'b0;
        accessAck   = 1'b0;
        accessAbort = 1'b0;
        misalign    = 1'b0;
        case (state)
            IDLE: begin
                if (memop) begin
                    if (aligned) begin
                        stall_mem   = 1'b1;
                        startAccess = 1'b1;
                        stateNext   = REQ;
                    end else begin
                        misalign    = 1'b1;
                    end
                end
            end
            REQ: begin
                stall_mem = 1'b1;
                // A late ack on the final cycle still counts as success
                if (dmem_ack) begin
                    accessAck = 1'b1;
                    stateNext = DONE;
                end else if (cnt == CntW'(TIMEOUT - 1)) begin
                    accessAbort = 1'b1;
                    stateNext   = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        // Never hold the pipeline while the block is in reset
        if (!reset) stall_mem = 1'b0;
    end

    // Bus request, cycle counter, captured read data and error pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'd0;
            dmem_wdata   <= 32'd0;
            cnt          <= '0;
            timedOut     <= 1'b0;
            rdataQ       <= 32'd0;
            misalign_err <= 1'b0;
            bus_timeout  <= 1'b0;
        end else begin
            if (startAccess) begin
                // Store wins when both store and load are flagged
                dmem_req   <= 1'b1;
                dmem_we    <= MemWrite_mem;
                dmem_addr  <= {ALUResult_mem[31:2], 2'b00};
                dmem_wdata <= MemWriteData_mem;
            end else if (accessAck || accessAbort) begin
                dmem_req   <= 1'b0;
            end

            if (state == REQ) cnt <= cnt + CntW'(1);
            else              cnt <= '0;

            if (accessAck) rdataQ <= dmem_rdata;

            if (accessAbort)        timedOut <= 1'b1;
            else if (state == IDLE) timedOut <= 1'b0;

            misalign_err <= misalign;
            bus_timeout  <= accessAbort;
        end
    end

    // MEM/WB register: bubble while stalled, retire otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite_wb     <= 1'b0;
            RegWriteAddr_wb <= 5'd0;
            MemToReg_wb     <= 1'b0;
            ReadData_wb     <= 32'd0;
            ALUResult_wb    <= 32'd0;
        end else if (stall_mem) begin
            RegWrite_wb <= 1'b0;
            MemToReg_wb <= 1'b0;
        end else if (state == DONE) begin
            RegWrite_wb     <= RegWrite_mem & ~timedOut;
            MemToReg_wb     <= MemToReg_mem & ~MemWrite_mem & ~timedOut;
            RegWriteAddr_wb <= RegWriteAddr_mem;
            ReadData_wb     <= rdataQ;
            ALUResult_wb    <= ALUResult_mem;
        end else begin
            // IDLE without an access: plain ALU op or a dropped misaligned access
            RegWrite_wb     <= RegWrite_mem & ~misalign;
            MemToReg_wb     <= 1'b0;
            RegWriteAddr_wb <= RegWriteAddr_mem;
            ALUResult_wb    <= ALUResult_mem;
        end
    end

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
module tb_mem_stage_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite_mem, MemToReg_mem, RegWrite_mem;
    logic [4:0]  RegWriteAddr_mem;
    logic [31:0] ALUResult_mem, MemWriteData_mem;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    logic        dmem_req, dmem_we, stall_mem;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        RegWrite_wb, MemToReg_wb, misalign_err, bus_timeout;
    logic [4:0]  RegWriteAddr_wb;
    logic [31:0] ReadData_wb, ALUResult_wb;

    // Second instance with a short timeout; it has its own memop controls and never sees an ack
    logic        tMemWrite, tMemToReg;
    logic        tAck;
    logic        tReq, tWe, tStall, tRegWrite, tMemToRegWb, tMisalign, tTimeout;
    logic [31:0] tAddr, tWdata, tReadData, tAluRes;
    logic [4:0]  tRegAddr;

    int nAsserts = 0;
    int nFail    = 0;

    always #5 clk = ~clk;

    mem_stage_dmem_ctrl #(.TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .MemWrite_mem(MemWrite_mem), .MemToReg_mem(MemToReg_mem), .RegWrite_mem(RegWrite_mem),
        .RegWriteAddr_mem(RegWriteAddr_mem), .ALUResult_mem(ALUResult_mem),
        .MemWriteData_mem(MemWriteData_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
        .RegWrite_wb(RegWrite_wb), .RegWriteAddr_wb(RegWriteAddr_wb), .MemToReg_wb(MemToReg_wb),
        .ReadData_wb(ReadData_wb), .ALUResult_wb(ALUResult_wb),
        .misalign_err(misalign_err), .bus_timeout(bus_timeout)
    );

    mem_stage_dmem_ctrl #(.TIMEOUT(4)) dutT (
        .clk(clk), .reset(reset),
        .MemWrite_mem(tMemWrite), .MemToReg_mem(tMemToReg), .RegWrite_mem(RegWrite_mem),
        .RegWriteAddr_mem(RegWriteAddr_mem), .ALUResult_mem(ALUResult_mem),
        .MemWriteData_mem(MemWriteData_mem),
        .dmem_req(tReq), .dmem_we(tWe), .dmem_addr(tAddr), .dmem_wdata(tWdata),
        .dmem_ack(tAck), .dmem_rdata(dmem_rdata), .stall_mem(tStall),
        .RegWrite_wb(tRegWrite), .RegWriteAddr_wb(tRegAddr), .MemToReg_wb(tMemToRegWb),
        .ReadData_wb(tReadData), .ALUResult_wb(tAluRes),
        .misalign_err(tMisalign), .bus_timeout(tTimeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic setIn(input logic mw, input logic mr, input logic rw, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] wd);
        MemWrite_mem     = mw;
        MemToReg_mem     = mr;
        RegWrite_mem     = rw;
        RegWriteAddr_mem = rd;
        ALUResult_mem    = alu;
        MemWriteData_mem = wd;
    endtask

    initial begin
        reset = 1'b0;
        setIn(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        tMemWrite = 1'b0; tMemToReg = 1'b0; tAck = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall_mem}, 32'd0);
        chk("rst_regwrite", {31'd0, RegWrite_wb}, 32'd0);
        chk("rst_readdata", ReadData_wb, 32'd0);
        reset = 1'b1;
        tick();

        // Load 0x40, ack on first REQ cycle
        setIn(1'b0, 1'b1, 1'b1, 5'd5, 32'h40, 32'd0);
        #1 chk("ld_stall_idle", {31'd0, stall_mem}, 32'd1);
        tick();
        chk("ld_req", {31'd0, dmem_req}, 32'd1);
        chk("ld_we", {31'd0, dmem_we}, 32'd0);
        chk("ld_addr", dmem_addr, 32'h40);
        chk("ld_bubble1", {31'd0, RegWrite_wb}, 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1 chk("ld_stall_req", {31'd0, stall_mem}, 32'd1);
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        chk("ld_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("ld_stall_done", {31'd0, stall_mem}, 32'd0);
        chk("ld_bubble2", {31'd0, RegWrite_wb}, 32'd0);
        tick();
        chk("ld_wb_rw", {31'd0, RegWrite_wb}, 32'd1);
        chk("ld_wb_m2r", {31'd0, MemToReg_wb}, 32'd1);
        chk("ld_wb_data", ReadData_wb, 32'hDEADBEEF);
        chk("ld_wb_rd", {27'd0, RegWriteAddr_wb}, 32'd5);
        setIn(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        tick();
        chk("ld_wb_once", {31'd0, RegWrite_wb}, 32'd0);

        // Store 0x80 / 0x1234, ack on the fifth REQ cycle
        setIn(1'b1, 1'b0, 1'b0, 5'd0, 32'h80, 32'h1234);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("st_req", {31'd0, dmem_req}, 32'd1);
            chk("st_we", {31'd0, dmem_we}, 32'd1);
            chk("st_addr", dmem_addr, 32'h80);
            chk("st_wdata", dmem_wdata, 32'h1234);
            chk("st_stall", {31'd0, stall_mem}, 32'd1);
            if (i == 4) dmem_ack = 1'b1;
            tick();
        end
        dmem_ack = 1'b0;
        chk("st_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("st_stall_done", {31'd0, stall_mem}, 32'd0);
        tick();
        chk("st_wb_rw", {31'd0, RegWrite_wb}, 32'd0);
        chk("st_wb_m2r", {31'd0, MemToReg_wb}, 32'd0);
        setIn(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        tick();

        // Misaligned load 0x42
        setIn(1'b0, 1'b1, 1'b1, 5'd7, 32'h42, 32'd0);
        #1 chk("mis_stall", {31'd0, stall_mem}, 32'd0);
        tick();
        chk("mis_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        chk("mis_rw", {31'd0, RegWrite_wb}, 32'd0);
        setIn(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        tick();
        chk("mis_err_pulse", {31'd0, misalign_err}, 32'd0);

        // Back-to-back: add, load, add
        setIn(1'b0, 1'b0, 1'b1, 5'd3, 32'd7, 32'd0);
        #1 chk("b2b_add_stall", {31'd0, stall_mem}, 32'd0);
        tick();
        chk("b2b_add_rw", {31'd0, RegWrite_wb}, 32'd1);
        chk("b2b_add_res", ALUResult_wb, 32'd7);
        chk("b2b_add_rd", {27'd0, RegWriteAddr_wb}, 32'd3);
        setIn(1'b0, 1'b1, 1'b1, 5'd4, 32'h44, 32'd0);
        tick();
        chk("b2b_bub1", {31'd0, RegWrite_wb}, 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        tick();
        dmem_ack = 1'b0;
        chk("b2b_bub2", {31'd0, RegWrite_wb}, 32'd0);
        tick();
        chk("b2b_ld_rw", {31'd0, RegWrite_wb}, 32'd1);
        chk("b2b_ld_m2r", {31'd0, MemToReg_wb}, 32'd1);
        chk("b2b_ld_data", ReadData_wb, 32'hCAFEF00D);
        chk("b2b_ld_rd", {27'd0, RegWriteAddr_wb}, 32'd4);
        setIn(1'b0, 1'b0, 1'b1, 5'd6, 32'h99, 32'd0);
        tick();
        chk("b2b_add2_rw", {31'd0, RegWrite_wb}, 32'd1);
        chk("b2b_add2_m2r", {31'd0, MemToReg_wb}, 32'd0);
        chk("b2b_add2_res", ALUResult_wb, 32'h99);
        chk("b2b_add2_rd", {27'd0, RegWriteAddr_wb}, 32'd6);

        // Reset in the middle of a request
        setIn(1'b0, 1'b1, 1'b1, 5'd9, 32'h100, 32'd0);
        tick();
        chk("rmid_req", {31'd0, dmem_req}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rmid_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("rmid_stall", {31'd0, stall_mem}, 32'd0);
        chk("rmid_alu", ALUResult_wb, 32'd0);
        chk("rmid_rd", {27'd0, RegWriteAddr_wb}, 32'd0);
        chk("rmid_rdata", ReadData_wb, 32'd0);
        setIn(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
        tick();
        chk("rmid_held", {31'd0, dmem_req}, 32'd0);
        reset = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("rmid_ack_ign_req", {31'd0, dmem_req}, 32'd0);
        chk("rmid_ack_ign_rdata", ReadData_wb, 32'd0);
        chk("rmid_ack_ign_stall", {31'd0, stall_mem}, 32'd0);

        // Timeout on the TIMEOUT=4 instance
        setIn(1'b0, 1'b0, 1'b1, 5'd10, 32'hC0, 32'd0);
        tMemToReg = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_req", {31'd0, tReq}, 32'd1);
            chk("to_stall", {31'd0, tStall}, 32'd1);
            chk("to_no_pulse", {31'd0, tTimeout}, 32'd0);
            tick();
        end
        chk("to_req_drop", {31'd0, tReq}, 32'd0);
        chk("to_pulse", {31'd0, tTimeout}, 32'd1);
        chk("to_stall_done", {31'd0, tStall}, 32'd0);
        tick();
        chk("to_pulse_end", {31'd0, tTimeout}, 32'd0);
        chk("to_wb_rw", {31'd0, tRegWrite}, 32'd0);
        chk("to_wb_m2r", {31'd0, tMemToRegWb}, 32'd0);
        tMemToReg = 1'b0;
        setIn(1'b0, 1'b0, 1'b1, 5'd11, 32'd5, 32'd0);
        #1 chk("to_resume_stall", {31'd0, tStall}, 32'd0);
        tick();
        chk("to_resume_rw", {31'd0, tRegWrite}, 32'd1);
        chk("to_resume_res", tAluRes, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
